// File: rtl/led_pattern_driver.sv
// Multi-channel alarm/status LED driver: a shared prescaler produces slow and
// fast blink ticks; each channel has its own mode, acknowledge and auto-silence.
module led_pattern_driver #(
    parameter int CHANNELS      = 4,
    parameter int TICK_DIV      = 25_000_000,
    parameter int TIMEOUT_TICKS = 120
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   ack,
    output logic [CHANNELS-1:0]   led_out,
    output logic [CHANNELS-1:0]   timed_out
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_SLOW   = 2'b10,
        MODE_FAST   = 2'b11
    } mode_e;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);

    // A zero timeout still needs a 1-bit counter so the per-channel logic elaborates.
    localparam bit TMO_EN = (TIMEOUT_TICKS > 0);
    localparam int TMO_W  = TMO_EN ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_TICKS : 0);
    localparam logic [TMO_W-1:0] TMO_PRE  = TMO_W'(TMO_EN ? TIMEOUT_TICKS - 1 : 0);

    // Shared prescaler
    logic [CNT_W-1:0] cnt_q;
    logic             slow_tick;
    logic             fast_tick;

    assign slow_tick = (cnt_q == CNT_LAST);
    assign fast_tick = (cnt_q == CNT_HALF) || slow_tick;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (slow_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Per-channel state
    mode_e             mode_in  [CHANNELS];
    mode_e             mode_q   [CHANNELS];
    mode_e             mode_d   [CHANNELS];
    logic [TMO_W-1:0]  tmo_q    [CHANNELS];
    logic [TMO_W-1:0]  tmo_d    [CHANNELS];
    logic [CHANNELS-1:0] led_q;
    logic [CHANNELS-1:0] led_d;
    logic [CHANNELS-1:0] acked_q;
    logic [CHANNELS-1:0] acked_d;
    logic [CHANNELS-1:0] to_q;
    logic [CHANNELS-1:0] to_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_mode_in
        assign mode_in[g] = mode_e'(mode[2*g +: 2]);
    end

    // NOTE: every output of this block gets a hold-value default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        led_d   = led_q;
        acked_d = acked_q;
        to_d    = to_q;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i] = mode_q[i];
            tmo_d[i]  = tmo_q[i];
        end

        for (int i = 0; i < CHANNELS; i++) begin
            if (mode_in[i] != mode_q[i]) begin
                // A new mode restarts everything; blinks always open lit.
                mode_d[i]  = mode_in[i];
                acked_d[i] = 1'b0;
                to_d[i]    = 1'b0;
                tmo_d[i]   = '0;
                led_d[i]   = (mode_in[i] != MODE_OFF);
            end else if (acked_q[i] || to_q[i]) begin
                led_d[i] = 1'b0;
            end else if (ack[i] && (mode_in[i] inside {MODE_SLOW, MODE_FAST})) begin
                acked_d[i] = 1'b1;
                led_d[i]   = 1'b0;
            end else begin
                case (mode_in[i])
                    MODE_OFF:    led_d[i] = 1'b0;
                    MODE_STEADY: led_d[i] = 1'b1;
                    MODE_SLOW:   if (slow_tick) led_d[i] = ~led_q[i];
                    MODE_FAST:   if (fast_tick) led_d[i] = ~led_q[i];
                    default:     led_d[i] = 1'b0;
                endcase

                // Expiry overrides the toggle computed above.
                if (TMO_EN && slow_tick && (mode_in[i] inside {MODE_SLOW, MODE_FAST})
                    && (tmo_q[i] != TMO_LAST)) begin
                    tmo_d[i] = tmo_q[i] + TMO_W'(1);
                    if (tmo_q[i] == TMO_PRE) begin
                        to_d[i]  = 1'b1;
                        led_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: these arrays are a handful of flops per channel rather than a RAM,
    // so every element is cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            acked_q <= '0;
            to_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= MODE_OFF;
                tmo_q[i]  <= '0;
            end
        end else begin
            led_q   <= led_d;
            acked_q <= acked_d;
            to_q    <= to_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= mode_d[i];
                tmo_q[i]  <= tmo_d[i];
            end
        end
    end

    assign led_out   = led_q;
    assign timed_out = to_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Scoreboard bench for led_pattern_driver: a behavioural model pushes the expected
// {timed_out, led_out} for each driven cycle, popped and compared after the edge.
module tb_led_pattern_driver;

    localparam int CH = 2;
    localparam int TD = 4;
    localparam int TT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] ack;
    logic [CH-1:0] led_out;
    logic [CH-1:0] timed_out;

    always #5 clk = ~clk;

    led_pattern_driver #(
        .CHANNELS      (CH),
        .TICK_DIV      (TD),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .ack       (ack),
        .led_out   (led_out),
        .timed_out (timed_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    int m_cnt;
    int m_mode  [CH];
    int m_tmo   [CH];
    bit m_led   [CH];
    bit m_acked [CH];
    bit m_to    [CH];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0; m_tmo[c] = 0; m_led[c] = 0; m_acked[c] = 0; m_to[c] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] mv, input logic [1:0] av);
        bit slow, fast, blink;
        int md;
        slow = (m_cnt == TD - 1);
        fast = (m_cnt == TD / 2 - 1) || slow;
        for (int c = 0; c < CH; c++) begin
            md    = int'(mv[2*c +: 2]);
            blink = (md >= 2);
            if (md != m_mode[c]) begin
                m_mode[c] = md; m_acked[c] = 0; m_tmo[c] = 0; m_to[c] = 0;
                m_led[c]  = (md != 0);
            end else if (m_acked[c] || m_to[c]) begin
                m_led[c] = 0;
            end else if (av[c] && blink) begin
                m_acked[c] = 1; m_led[c] = 0;
            end else begin
                if (md == 0) m_led[c] = 0;
                else if (md == 1) m_led[c] = 1;
                else if (md == 2 && slow) m_led[c] = !m_led[c];
                else if (md == 3 && fast) m_led[c] = !m_led[c];
                if (blink && slow) begin
                    m_tmo[c]++;
                    if (m_tmo[c] == TT) begin
                        m_to[c] = 1; m_led[c] = 0;
                    end
                end
            end
        end
        m_cnt = (m_cnt + 1) % TD;
        exp_q.push_back({m_to[1], m_to[0], m_led[1], m_led[0]});
    endtask

    task automatic step(input logic [3:0] mv, input logic [1:0] av, input string tag);
        logic [3:0] e;
        @(negedge clk);
        mode = mv;
        ack  = av;
        model_step(mv, av);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'({timed_out, led_out}), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] mv;
        logic [1:0] av;
        int guard;

        reset = 1'b1;
        mode  = '0;
        ack   = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_led", 32'(led_out), 32'(0));
        check("rst_tmo", 32'(timed_out), 32'(0));
        reset = 1'b0;

        // Idle in off mode until the prescaler is back at 0
        for (int k = 0; k < 4; k++) step(4'b0000, 2'b00, "idle_off");

        // ch0 slow, ch1 fast, both applied while cnt=0
        step(4'b1110, 2'b00, "blink_start");
        check("blink_first_lit", 32'(led_out), 32'(2'b11));
        for (int k = 0; k < 9; k++) step(4'b1110, 2'b00, "blink_run");

        // ack ch0 mid-blink; ch1 keeps blinking and then times out
        step(4'b1110, 2'b01, "ack_ch0");
        for (int k = 0; k < 6; k++) step(4'b1110, 2'b00, "acked_hold");
        check("acked_dark", 32'(led_out[0]), 32'(0));

        // steady mode lights immediately and ignores ack
        step(4'b1101, 2'b00, "steady_on");
        check("steady_lit", 32'(led_out[0]), 32'(1));
        step(4'b1101, 2'b01, "steady_ack");
        step(4'b1101, 2'b01, "steady_ack");
        check("steady_ack_ignored", 32'(led_out[0]), 32'(1));

        // ch0 slow with no ack runs into the timeout
        for (int k = 0; k < 16; k++) step(4'b0010, 2'b00, "tmo_run");
        check("tmo_flag", 32'(timed_out[0]), 32'(1));
        check("tmo_dark", 32'(led_out[0]), 32'(0));
        step(4'b0010, 2'b01, "tmo_ack");
        step(4'b0000, 2'b00, "tmo_clear");
        check("tmo_cleared", 32'(timed_out[0]), 32'(0));

        // slow -> fast switch landing on a slow_tick edge
        for (int k = 0; k < 4; k++) step(4'b0010, 2'b00, "pre_switch");
        guard = 0;
        while (m_cnt != TD - 1 && guard < 8) begin
            step(4'b0010, 2'b00, "pre_switch");
            guard++;
        end
        check("switch_on_tick", 32'(m_cnt), 32'(TD - 1));
        step(4'b0011, 2'b00, "switch_fast");
        check("switch_lit", 32'(led_out[0]), 32'(1));
        for (int k = 0; k < 9; k++) step(4'b0011, 2'b00, "fast_after_switch");
        check("switch_tmo_restart", 32'(timed_out[0]), 32'(0));

        // asynchronous reset while ch1 is lit mid-blink
        step(4'b1100, 2'b00, "pre_reset");
        check("pre_reset_lit", 32'(led_out[1]), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_led", 32'(led_out), 32'(0));
        check("async_rst_tmo", 32'(timed_out), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) step(4'b1100, 2'b00, "post_reset");

        // random soak with sparse mode changes and acks
        mv = 4'b1010;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) mv = 4'($urandom_range(0, 15));
            av = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            step(mv, av, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
